// File: rtl/test_ram_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : test_ram_initiator_cmd_if / test_ram_bus_if
//  Description : Bundles for the TestRam initiator.
//                test_ram_initiator_cmd_if - core-side command/response
//                channel (master = core, slave = initiator).
//                test_ram_bus_if - TestRam request/ready bus
//                (master = initiator, slave = TestRam).
//  Revision    : 1.0 - initial release
// ============================================================================

interface test_ram_initiator_cmd_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_we;
    logic                      cmd_wide;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [2*DATA_WIDTH-1:0]   cmd_wdata;
    logic                      rsp_valid;
    logic [2*DATA_WIDTH-1:0]   rsp_rdata;
    logic                      rsp_err;

    modport master (
        output cmd_valid, cmd_we, cmd_wide, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_wide, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface test_ram_bus_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8
);
    logic                      req_rdwr;
    logic                      we;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     data_out;
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      data_ready;

    modport master (
        output req_rdwr, we, addr, data_out,
        input  data_in, data_ready
    );

    modport slave (
        input  req_rdwr, we, addr, data_out,
        output data_in, data_ready
    );
endinterface

`default_nettype wire

// File: rtl/test_ram_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : test_ram_initiator
//  Description : Bus-master end of the TestRam request/ready protocol.
//                Turns byte or 16-bit little-endian read/write commands from
//                the core into one or two TestRam byte transactions, with a
//                one-cycle req_rdwr-low gap between the two halves of a wide
//                access and an optional watchdog on data_ready.
//  Revision    : 1.0 - initial release
// ============================================================================

module test_ram_initiator #(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire                         clk,
    input  wire                         reset_n,
    test_ram_initiator_cmd_if.slave     cmd,
    test_ram_bus_if.master              ram
);

    // Watchdog counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int c_WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam int c_WD_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST_V = c_WD_LAST[c_WD_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ_LO = 2'd1,
        S_GAP    = 2'd2,
        S_REQ_HI = 2'd3
    } state_t;

    state_t                  r_state;

    // Latched command fields
    logic                    r_cmd_we;
    logic                    r_cmd_wide;
    logic [ADDR_WIDTH-1:0]   r_cmd_addr;
    logic [DATA_WIDTH-1:0]   r_wdata_hi;
    logic [DATA_WIDTH-1:0]   r_rd_lo;

    // Registered TestRam-side outputs
    logic                    r_req_rdwr;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data_out;

    // Registered response outputs
    logic                    r_rsp_valid;
    logic                    r_rsp_err;
    logic [2*DATA_WIDTH-1:0] r_rsp_rdata;

    logic [c_WD_W-1:0]       r_wdog;

    logic                    w_wd_expire;

    // Watchdog fires on the edge that would be the TIMEOUT_CYCLES-th without data_ready.
    assign w_wd_expire = c_WD_EN && (r_wdog == c_WD_LAST_V);

    // Command acceptance is gated by reset so nothing is taken while held in reset.
    assign cmd.cmd_ready = (r_state == S_IDLE) && reset_n;

    assign cmd.rsp_valid = r_rsp_valid;
    assign cmd.rsp_err   = r_rsp_err;
    assign cmd.rsp_rdata = r_rsp_rdata;

    assign ram.req_rdwr  = r_req_rdwr;
    assign ram.we        = r_we;
    assign ram.addr      = r_addr;
    assign ram.data_out  = r_data_out;

    // Transaction sequencer: state, TestRam drive, watchdog and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cmd_we    <= 1'b0;
            r_cmd_wide  <= 1'b0;
            r_cmd_addr  <= '0;
            r_wdata_hi  <= '0;
            r_rd_lo     <= '0;
            r_req_rdwr  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data_out  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_wdog      <= '0;
        end else begin
            // Response flags are single-cycle pulses.
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        r_cmd_we   <= cmd.cmd_we;
                        r_cmd_wide <= cmd.cmd_wide;
                        r_cmd_addr <= cmd.cmd_addr;
                        r_wdata_hi <= cmd.cmd_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_addr     <= cmd.cmd_addr;
                        r_data_out <= cmd.cmd_wdata[DATA_WIDTH-1:0];
                        r_we       <= cmd.cmd_we;
                        r_req_rdwr <= 1'b1;
                        r_wdog     <= '0;
                        r_state    <= S_REQ_LO;
                    end
                end

                S_REQ_LO, S_REQ_HI: begin
                    if (ram.data_ready) begin
                        // Drop the request on the capture edge so it never lingers.
                        r_req_rdwr <= 1'b0;
                        r_we       <= 1'b0;
                        r_wdog     <= '0;
                        if (r_state == S_REQ_LO) begin
                            r_rd_lo <= ram.data_in;
                            if (r_cmd_wide) begin
                                r_state <= S_GAP;
                            end else begin
                                r_rsp_valid <= 1'b1;
                                if (!r_cmd_we) begin
                                    r_rsp_rdata <= {{DATA_WIDTH{1'b0}}, ram.data_in};
                                end
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_rsp_valid <= 1'b1;
                            if (!r_cmd_we) begin
                                r_rsp_rdata <= {ram.data_in, r_rd_lo};
                            end
                            r_state <= S_IDLE;
                        end
                    end else if (w_wd_expire) begin
                        // Abandon the command; rsp_rdata keeps its last value.
                        r_req_rdwr  <= 1'b0;
                        r_we        <= 1'b0;
                        r_wdog      <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + c_WD_W'(1);
                    end
                end

                S_GAP: begin
                    // One req_rdwr-low cycle lets the responder reset its phase.
                    r_addr     <= r_cmd_addr + ADDR_WIDTH'(1);
                    r_data_out <= r_wdata_hi;
                    r_we       <= r_cmd_we;
                    r_req_rdwr <= 1'b1;
                    r_wdog     <= '0;
                    r_state    <= S_REQ_HI;
                end

                default: begin
                    r_req_rdwr <= 1'b0;
                    r_we       <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_test_ram_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_ram_initiator
//  Description : Self-checking bench for test_ram_initiator with a
//                2-cycle-ready TestRam responder model and a response
//                scoreboard (data, error flag, latency).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_test_ram_initiator;

    localparam int AW = 24;
    localparam int DW = 8;
    localparam int TO = 8;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          hs;
    } exp_t;

    typedef struct {
        logic [23:0] a;
        logic        w;
        logic [7:0]  d;
    } blog_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    test_ram_initiator_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cmd_bus ();
    test_ram_bus_if           #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

    test_ram_initiator #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cmd     (cmd_bus.slave),
        .ram     (ram_bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t  exp_q[$];
    blog_t bus_log[$];
    int    hi_q[$];
    int    lo_q[$];
    int    hi_run = 0;
    int    lo_run = 0;

    // Reference memory for expected read data (low address byte indexes it).
    logic [7:0]  ref_mem [256];
    logic [15:0] last_rd = 16'h0000;

    // ---------------- TestRam responder model ----------------
    logic [7:0] ram_mem [256];
    int         phase = 0;
    logic       rsp_dr = 1'b0;
    logic [7:0] rsp_dout = 8'h00;
    logic       stall = 1'b0;

    assign ram_bus.data_ready = rsp_dr;
    assign ram_bus.data_in    = rsp_dout;

    // Responder: ready raised on the second edge of a request, cleared when req drops.
    always @(posedge clk) begin
        if (!ram_bus.req_rdwr) begin
            phase  <= 0;
            rsp_dr <= 1'b0;
        end else if (phase == 0) begin
            phase <= 1;
        end else if (phase == 1) begin
            phase <= 2;
            bus_log.push_back('{a: ram_bus.addr, w: ram_bus.we, d: ram_bus.data_out});
            if (ram_bus.we) ram_mem[ram_bus.addr[7:0]] <= ram_bus.data_out;
            if (!stall) begin
                rsp_dr   <= 1'b1;
                rsp_dout <= ram_mem[ram_bus.addr[7:0]];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Monitor: scoreboard pops on rsp_valid, protocol check, req run lengths.
    always @(negedge clk) begin
        if (reset_n) begin
            check("we_without_req", {31'd0, ram_bus.we & ~ram_bus.req_rdwr}, 32'd0);
            if (cmd_bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", {16'd0, cmd_bus.rsp_rdata}, {16'd0, e.rdata});
                    check("rsp_err", {31'd0, cmd_bus.rsp_err}, {31'd0, e.err});
                    check("rsp_latency", cyc - e.hs, e.lat);
                end
            end
        end
        if (ram_bus.req_rdwr) begin
            if (hi_run == 0) lo_q.push_back(lo_run);
            lo_run = 0;
            hi_run++;
        end else begin
            if (hi_run != 0) hi_q.push_back(hi_run);
            hi_run = 0;
            lo_run++;
        end
    end

    // Present a command (called just after a negedge) and wait for its handshake edge.
    task automatic send(input logic w, input logic wide, input logic [23:0] a,
                        input logic [15:0] d, input int lat, input bit err, input bit track);
        int          n = 0;
        exp_t        e;
        logic [23:0] a1;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_we    = w;
        cmd_bus.cmd_wide  = wide;
        cmd_bus.cmd_addr  = a;
        cmd_bus.cmd_wdata = d;
        #1;
        while (!cmd_bus.cmd_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_bus.cmd_ready) begin
            check("accept_timeout", 32'd1, 32'd0);
            return;
        end
        a1 = a + 24'd1;
        e.hs  = cyc + 1;
        e.lat = lat;
        e.err = err;
        if (err || w) e.rdata = last_rd;
        else if (wide) e.rdata = {ref_mem[a1[7:0]], ref_mem[a[7:0]]};
        else e.rdata = {8'h00, ref_mem[a[7:0]]};
        if (w && !err) begin
            ref_mem[a[7:0]] = d[7:0];
            if (wide) ref_mem[a1[7:0]] = d[15:8];
        end
        if (track) begin
            last_rd = e.rdata;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int hm;
        int lm;
        int bm;
        int n;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_we    = 1'b0;
        cmd_bus.cmd_wide  = 1'b0;
        cmd_bus.cmd_addr  = '0;
        cmd_bus.cmd_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd0);
        check("rst_req_rdwr", {31'd0, ram_bus.req_rdwr}, 32'd0);
        check("rst_we", {31'd0, ram_bus.we}, 32'd0);
        check("rst_rsp_valid", {31'd0, cmd_bus.rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'd0, cmd_bus.rsp_err}, 32'd0);
        check("rst_addr", {8'd0, ram_bus.addr}, 32'd0);
        check("rst_data_out", {24'd0, ram_bus.data_out}, 32'd0);
        check("rst_rsp_rdata", {16'd0, cmd_bus.rsp_rdata}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        @(negedge clk);

        // Byte write then read
        send(1'b1, 1'b0, 24'h000010, 16'h005A, 3, 1'b0, 1'b1); idle(); drain();
        send(1'b0, 1'b0, 24'h000010, 16'h0000, 3, 1'b0, 1'b1); idle(); drain();

        // Wide write: two byte transactions with a single-cycle gap
        hm = hi_q.size(); lm = lo_q.size(); bm = bus_log.size();
        send(1'b1, 1'b1, 24'h000020, 16'hBEEF, 7, 1'b0, 1'b1); idle(); drain();
        check("ww_log_count", bus_log.size() - bm, 32'd2);
        if (bus_log.size() - bm == 2) begin
            check("ww_addr0", {8'd0, bus_log[bm].a}, 32'h20);
            check("ww_data0", {24'd0, bus_log[bm].d}, 32'hEF);
            check("ww_we0", {31'd0, bus_log[bm].w}, 32'd1);
            check("ww_addr1", {8'd0, bus_log[bm+1].a}, 32'h21);
            check("ww_data1", {24'd0, bus_log[bm+1].d}, 32'hBE);
        end
        check("ww_pulses", hi_q.size() - hm, 32'd2);
        check("ww_gap_len", lo_q.size() > lm + 1 ? lo_q[lm+1] : -1, 32'd1);
        send(1'b0, 1'b1, 24'h000020, 16'h0000, 7, 1'b0, 1'b1); idle(); drain();

        // Address wrap on a wide read
        send(1'b1, 1'b0, 24'hFFFFFF, 16'h00A5, 3, 1'b0, 1'b1); idle(); drain();
        send(1'b1, 1'b0, 24'h000000, 16'h003C, 3, 1'b0, 1'b1); idle(); drain();
        bm = bus_log.size();
        send(1'b0, 1'b1, 24'hFFFFFF, 16'h0000, 7, 1'b0, 1'b1); idle(); drain();
        check("wrap_addr_hi", bus_log.size() > bm + 1 ? {8'd0, bus_log[bm+1].a} : 32'hDEAD, 32'h0);

        // Back-to-back byte reads with cmd_valid held high
        hm = hi_q.size(); lm = lo_q.size();
        send(1'b0, 1'b0, 24'h000010, 16'h0000, 3, 1'b0, 1'b1);
        send(1'b0, 1'b0, 24'h000020, 16'h0000, 3, 1'b0, 1'b1);
        send(1'b0, 1'b0, 24'h000021, 16'h0000, 3, 1'b0, 1'b1);
        send(1'b0, 1'b0, 24'hFFFFFF, 16'h0000, 3, 1'b0, 1'b1);
        idle(); drain();
        check("b2b_pulses", hi_q.size() - hm, 32'd4);
        for (int i = hm; i < hi_q.size(); i++) check("b2b_pulse_len", hi_q[i], 32'd3);
        for (int i = lm + 1; i < lo_q.size(); i++) check("b2b_gap_min", {31'd0, lo_q[i] >= 1}, 32'd1);

        // Watchdog timeout
        stall = 1'b1;
        hm = hi_q.size();
        send(1'b0, 1'b0, 24'h000040, 16'h0000, TO, 1'b1, 1'b1); idle(); drain();
        check("to_req_len", hi_q.size() > hm ? hi_q[hi_q.size()-1] : -1, TO);
        check("to_cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        stall = 1'b0;

        // Async reset during the gap of a wide write
        send(1'b1, 1'b1, 24'h000050, 16'h1234, 7, 1'b0, 1'b0);
        idle();
        n = 0;
        while (ram_bus.req_rdwr && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("gap_reached", {31'd0, ram_bus.req_rdwr}, 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("ar_req_rdwr", {31'd0, ram_bus.req_rdwr}, 32'd0);
        check("ar_we", {31'd0, ram_bus.we}, 32'd0);
        check("ar_rsp_valid", {31'd0, cmd_bus.rsp_valid}, 32'd0);
        check("ar_addr", {8'd0, ram_bus.addr}, 32'd0);
        check("ar_data_out", {24'd0, ram_bus.data_out}, 32'd0);
        check("ar_cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd0);
        last_rd = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ar_post_cmd_ready", {31'd0, cmd_bus.cmd_ready}, 32'd1);
        @(negedge clk);
        send(1'b0, 1'b0, 24'h000010, 16'h0000, 3, 1'b0, 1'b1); idle(); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
